// File: rtl/router_pkg.sv
// Shared definitions for the packet generator and router ports:
// FSM state encoding, default parameter values and the launch rule.
package router_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SRC  = 3'd1,
        DST  = 3'd2,
        LEN  = 3'd3,
        DATA = 3'd4,
        CRC  = 3'd5,
        GAP  = 3'd6
    } state_t;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_LEN_W   = 6;
    localparam int DEF_GAP_CYC = 0;
    localparam int DEF_CNT_W   = 16;

    // A new packet may start only while enabled and not held off.
    function automatic logic launch_ok(input logic start, input logic stop);
        return start & ~stop;
    endfunction

endpackage

// File: rtl/packet_tx_gen_if.sv
// Beat stream from the packet generator to its downstream consumer.
interface packet_tx_gen_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sop;
    logic              out_eop;

    modport master (
        output out_data,
        output out_valid,
        output out_sop,
        output out_eop,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_sop,
        input  out_eop,
        output out_ready
    );
endinterface

// File: rtl/pkt_xor_crc.sv
// Running XOR checksum over the beats of one packet.
module pkt_xor_crc #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_crc
);
    logic [DATA_W-1:0] r_crc;

    // Clear wins over accumulate so a launch always starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_crc <= '0;
        else if (i_clr)
            r_crc <= '0;
        else if (i_en)
            r_crc <= r_crc ^ i_data;
    end

    assign o_crc = r_crc;
endmodule

// File: rtl/packet_tx_gen.sv
// Packet generator: emits src, dst, length, payload (seed, seed+1, ...)
// and an XOR checksum beat, with optional idle gap between packets.
// The beat on the bus is registered; the next beat is prepared
// combinationally and loaded on each accepted transfer.
module packet_tx_gen
    import router_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int GAP_CYC = DEF_GAP_CYC,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [DATA_W-1:0] i_src_id,
    input  logic [DATA_W-1:0] i_dst_id,
    input  logic [LEN_W-1:0]  i_length,
    input  logic [DATA_W-1:0] i_seed,
    packet_tx_gen_if.master   tx,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_pkt_count
);
    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_src, r_dst, r_seed;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt, w_cnt_nxt;
    logic [15:0]       r_gap, w_gap_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_sop, w_sop_nxt;
    logic              r_eop, w_eop_nxt;
    logic              r_busy, w_busy_nxt;
    logic [CNT_W-1:0]  r_pkt_count;
    logic              w_xfer, w_go, w_launch, w_crc_en, w_pkt_inc;
    logic [DATA_W-1:0] w_crc;

    assign w_xfer = r_valid & tx.out_ready;
    assign w_go   = launch_ok(i_start, i_stop);

    pkt_xor_crc #(.DATA_W(DATA_W)) u_crc (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_launch),
        .i_en   (w_crc_en),
        .i_data (r_data),
        .o_crc  (w_crc)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next state and next beat; the checksum beat folds in the beat
    // being accepted this cycle, which the accumulator has not yet seen.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_sop_nxt   = r_sop;
        w_eop_nxt   = r_eop;
        w_busy_nxt  = r_busy;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap;
        w_launch    = 1'b0;
        w_crc_en    = 1'b0;
        w_pkt_inc   = 1'b0;
        case (r_state)
            IDLE: w_launch = w_go;
            SRC: if (w_xfer) begin
                w_state_nxt = DST;
                w_data_nxt  = r_dst;
                w_sop_nxt   = 1'b0;
                w_crc_en    = 1'b1;
            end
            DST: if (w_xfer) begin
                w_state_nxt = LEN;
                w_data_nxt  = DATA_W'(r_len);
                w_crc_en    = 1'b1;
            end
            LEN: if (w_xfer) begin
                w_crc_en  = 1'b1;
                w_cnt_nxt = r_len;
                if (r_len == '0) begin
                    w_state_nxt = CRC;
                    w_data_nxt  = w_crc ^ r_data;
                    w_eop_nxt   = 1'b1;
                end else begin
                    w_state_nxt = DATA;
                    w_data_nxt  = r_seed;
                end
            end
            DATA: if (w_xfer) begin
                w_crc_en  = 1'b1;
                w_cnt_nxt = r_cnt - LEN_W'(1);
                if (r_cnt == LEN_W'(1)) begin
                    w_state_nxt = CRC;
                    w_data_nxt  = w_crc ^ r_data;
                    w_eop_nxt   = 1'b1;
                end else begin
                    w_data_nxt  = r_data + DATA_W'(1);
                end
            end
            CRC: if (w_xfer) begin
                w_pkt_inc   = 1'b1;
                w_valid_nxt = 1'b0;
                w_eop_nxt   = 1'b0;
                w_busy_nxt  = 1'b0;
                w_data_nxt  = '0;
                if (GAP_CYC > 0) begin
                    w_state_nxt = GAP;
                    w_gap_nxt   = 16'(GAP_CYC - 1);
                end else begin
                    w_state_nxt = IDLE;
                    w_launch    = w_go;
                end
            end
            GAP: begin
                if (r_gap == 16'd0) begin
                    w_state_nxt = IDLE;
                    w_launch    = w_go;
                end else begin
                    w_gap_nxt = r_gap - 16'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_launch) begin
            w_state_nxt = SRC;
            w_data_nxt  = i_src_id;
            w_valid_nxt = 1'b1;
            w_sop_nxt   = 1'b1;
            w_eop_nxt   = 1'b0;
            w_busy_nxt  = 1'b1;
        end
    end

    // Launch-time capture of the packet fields; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (w_launch) begin
            r_src  <= i_src_id;
            r_dst  <= i_dst_id;
            r_len  <= i_length;
            r_seed <= i_seed;
        end
    end

    // Registered outputs, beat/gap counters and sent-packet counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_gap       <= '0;
            r_pkt_count <= '0;
        end else begin
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_sop   <= w_sop_nxt;
            r_eop   <= w_eop_nxt;
            r_busy  <= w_busy_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gap   <= w_gap_nxt;
            if (w_pkt_inc)
                r_pkt_count <= r_pkt_count + CNT_W'(1);
        end
    end

    assign tx.out_data  = r_data;
    assign tx.out_valid = r_valid;
    assign tx.out_sop   = r_sop;
    assign tx.out_eop   = r_eop;
    assign o_busy       = r_busy;
    assign o_pkt_count  = r_pkt_count;
endmodule
